// File: rtl/cache_fifo_rd_arbiter.sv
`default_nettype none
// ============================================================================
// cache_fifo_rd_arbiter
// Round-robin arbiter sharing the tagged cache FIFO read port among NUM_REQ
// requesters, with a WAIT watchdog. Optional per-requester grant counters
// are built when CFARB_STATS_EN is defined.
// Revision: 1.0
// ============================================================================
module cache_fifo_rd_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 8,
   parameter int TIMEOUT    = 15
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*TAG_WIDTH-1:0] req_tag,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [NUM_REQ-1:0]           resp_valid,
   input  logic [NUM_REQ-1:0]           resp_ready,
   output logic [DATA_WIDTH-1:0]        resp_data,
   output logic                         resp_hit,
   output logic                         resp_err,
   output logic                         fifo_rd_en,
   output logic [TAG_WIDTH-1:0]         fifo_rd_tag,
   input  logic [DATA_WIDTH-1:0]        fifo_rd_data,
   input  logic                         fifo_rd_valid,
   input  logic                         fifo_rd_hit,
   output logic                         busy,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic [NUM_REQ*16-1:0]        stat_grants
);

   localparam int              GW        = $clog2(NUM_REQ);
   localparam logic [GW:0]     C_NUM     = (GW+1)'(NUM_REQ);
   localparam logic [7:0]      C_TIMEOUT = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [GW-1:0]           rr_ptr_q, rr_ptr_d;
   logic [GW-1:0]           grant_id_q, grant_id_d;
   logic [TAG_WIDTH-1:0]    tag_q, tag_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
   logic                    resp_hit_q, resp_hit_d;
   logic                    resp_err_q, resp_err_d;

   logic [NUM_REQ-1:0]      rot_req;
   logic                    win_found;
   logic [GW-1:0]           win_off, win_id, win_next;
   logic [GW:0]             win_sum, next_sum;
   logic [TAG_WIDTH-1:0]    win_tag;
   logic                    accept;

   // Rotate requests so rr_ptr sits at bit 0; the lowest set bit is the winner.
   always_comb begin
      rot_req   = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);
      win_found = 1'b0;
      win_off   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot_req[i]) begin
            win_found = 1'b1;
            win_off   = GW'(i);
         end
      end
      win_sum = {1'b0, rr_ptr_q} + {1'b0, win_off};
      if (win_sum >= C_NUM) begin
         win_sum = win_sum - C_NUM;
      end
      win_id   = win_sum[GW-1:0];
      next_sum = {1'b0, win_id} + (GW+1)'(1);
      if (next_sum >= C_NUM) begin
         next_sum = '0;
      end
      win_next = next_sum[GW-1:0];
      win_tag  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_id == GW'(i)) begin
            win_tag = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
         end
      end
   end

   assign accept      = (state_q == IDLE) && win_found;
   assign req_ready   = (accept && rst_n) ? (NUM_REQ'(1) << win_id) : '0;
   assign resp_valid  = (state_q == RESP) ? (NUM_REQ'(1) << grant_id_q) : '0;
   assign resp_data   = resp_data_q;
   assign resp_hit    = resp_hit_q;
   assign resp_err    = resp_err_q;
   assign fifo_rd_en  = (state_q == ISSUE);
   assign fifo_rd_tag = (state_q == ISSUE) ? tag_q : '0;
   assign busy        = (state_q != IDLE);
   assign grant_id    = grant_id_q;

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_id_d  = grant_id_q;
      tag_d       = tag_q;
      cnt_d       = cnt_q;
      resp_data_d = resp_data_q;
      resp_hit_d  = resp_hit_q;
      resp_err_d  = resp_err_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               grant_id_d = win_id;
               rr_ptr_d   = win_next;
               tag_d      = win_tag;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + 8'd1;
            // A response landing on the timeout cycle still wins over the error.
            if (fifo_rd_valid) begin
               resp_data_d = fifo_rd_data;
               resp_hit_d  = fifo_rd_hit;
               resp_err_d  = 1'b0;
               state_d     = RESP;
            end else if (cnt_d == C_TIMEOUT) begin
               resp_data_d = '0;
               resp_hit_d  = 1'b0;
               resp_err_d  = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (|(resp_valid & resp_ready)) begin
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         grant_id_q  <= '0;
         tag_q       <= '0;
         cnt_q       <= '0;
         resp_data_q <= '0;
         resp_hit_q  <= 1'b0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_id_q  <= grant_id_d;
         tag_q       <= tag_d;
         cnt_q       <= cnt_d;
         resp_data_q <= resp_data_d;
         resp_hit_q  <= resp_hit_d;
         resp_err_q  <= resp_err_d;
      end
   end

`ifdef CFARB_STATS_EN
   logic [15:0] stat_q [NUM_REQ];
   logic [15:0] stat_d [NUM_REQ];

   always_comb begin
      stat_d = stat_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (accept && (win_id == GW'(i)) && (stat_q[i] != 16'hFFFF)) begin
            stat_d[i] = stat_q[i] + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            stat_q[i] <= '0;
         end
      end else begin
         stat_q <= stat_d;
      end
   end

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat_out
      assign stat_grants[gi*16 +: 16] = stat_q[gi];
   end
`else
   assign stat_grants = '0;
`endif

endmodule
`default_nettype wire
